// File: rtl/dmem_load_unit_pkg.sv
// rtl/dmem_load_unit_pkg.sv - core-wide memory op, data/address and load FSM types
package dmem_load_unit_pkg;

  typedef logic [63:0] data_t;
  typedef logic [63:0] addr_t;

  typedef enum logic [2:0] {
    MEM_NO,
    MEM_B,
    MEM_H,
    MEM_W,
    MEM_D,
    MEM_UB,
    MEM_UH,
    MEM_UW
  } mem_op_enum;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_REQ,
    LD_WAIT,
    LD_DONE,
    LD_DRAIN
  } load_state_enum;

  // A field is misaligned when its byte offset is not a multiple of its size.
  function automatic logic is_misaligned(input mem_op_enum op, input logic [2:0] lo);
    case (op)
      MEM_H, MEM_UH: return lo[0] != 1'b0;
      MEM_W, MEM_UW: return lo[1:0] != 2'b00;
      MEM_D:         return lo != 3'b000;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ld_data_unpack.sv
// rtl/ld_data_unpack.sv - extracts, shifts and extends one load field from a raw doubleword
module ld_data_unpack
  import dmem_load_unit_pkg::*;
#(
  parameter int DW = 64
) (
  input  mem_op_enum    mem_op_i,
  input  logic [2:0]    addr_lo_i,
  input  logic [DW-1:0] rdata_i,
  output logic [DW-1:0] data_o,
  output logic          misalign_o
);

  logic [DW-1:0] t;

  // Bring the addressed byte to bit 0 (zero fill), then size and extend the field.
  always_comb begin
    t      = rdata_i >> {addr_lo_i, 3'b000};
    data_o = '0;
    case (mem_op_i)
      MEM_B:   data_o = {{(DW-8){t[7]}}, t[7:0]};
      MEM_UB:  data_o = {{(DW-8){1'b0}}, t[7:0]};
      MEM_H:   data_o = {{(DW-16){t[15]}}, t[15:0]};
      MEM_UH:  data_o = {{(DW-16){1'b0}}, t[15:0]};
      MEM_W:   data_o = {{(DW-32){t[31]}}, t[31:0]};
      MEM_UW:  data_o = {{(DW-32){1'b0}}, t[31:0]};
      MEM_D:   data_o = t;
      default: data_o = '0;
    endcase
  end

  assign misalign_o = is_misaligned(mem_op_i, addr_lo_i);

endmodule

// File: rtl/dmem_load_unit.sv
// rtl/dmem_load_unit.sv - single-outstanding load unit between MEM stage and dmem read port (option: MISALIGN_CHECK_EN)
module dmem_load_unit
  import dmem_load_unit_pkg::*;
#(
  parameter int DW = 64,
  parameter int AW = 64
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  mem_op_enum    ld_op,
  input  logic [AW-1:0] ld_addr,
  output logic          dmem_ren,
  output logic [AW-1:0] dmem_raddr,
  input  logic          dmem_gnt,
  input  logic          dmem_rvalid,
  input  logic [DW-1:0] dmem_rdata,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          res_misalign
);

  load_state_enum state_q, state_d;
  mem_op_enum     op_q, op_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  res_data_q, res_data_d;

  mem_op_enum     unp_op;
  logic [2:0]     unp_lo;
  logic [DW-1:0]  unp_data;
  logic           unp_misalign;

  // In IDLE the unpacker looks at the incoming request (misalign decision);
  // afterwards it formats against the captured op and address.
  assign unp_op = (state_q == LD_IDLE) ? ld_op : op_q;
  assign unp_lo = (state_q == LD_IDLE) ? ld_addr[2:0] : addr_q[2:0];

  ld_data_unpack #(.DW(DW)) u_unpack (
    .mem_op_i   (unp_op),
    .addr_lo_i  (unp_lo),
    .rdata_i    (dmem_rdata),
    .data_o     (unp_data),
    .misalign_o (unp_misalign)
  );

`ifdef MISALIGN_CHECK_EN
  logic mis_q, mis_d;
`else
  logic unused_misalign;
  assign unused_misalign = unp_misalign;
`endif

  // Next-state and captured-value logic; flush is checked first in every state but DRAIN.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    res_data_d = res_data_q;
`ifdef MISALIGN_CHECK_EN
    mis_d      = mis_q;
`endif
    case (state_q)
      LD_IDLE: begin
        if (!flush && ld_valid && (ld_op != MEM_NO)) begin
          op_d    = ld_op;
          addr_d  = ld_addr;
          state_d = LD_REQ;
`ifdef MISALIGN_CHECK_EN
          mis_d   = 1'b0;
          if (unp_misalign) begin
            state_d    = LD_DONE;
            res_data_d = '0;
            mis_d      = 1'b1;
          end
`endif
        end
      end
      LD_REQ: begin
        if (flush) begin
          state_d = dmem_gnt ? LD_DRAIN : LD_IDLE;
        end else if (dmem_gnt) begin
          state_d = LD_WAIT;
        end
      end
      LD_WAIT: begin
        if (flush) begin
          state_d = dmem_rvalid ? LD_IDLE : LD_DRAIN;
        end else if (dmem_rvalid) begin
          res_data_d = unp_data;
          state_d    = LD_DONE;
        end
      end
      LD_DONE: begin
        if (flush || res_ready) begin
          state_d = LD_IDLE;
        end
      end
      LD_DRAIN: begin
        if (dmem_rvalid) begin
          state_d = LD_IDLE;
        end
      end
      default: state_d = LD_IDLE;
    endcase
  end

  // State and captured-request registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= LD_IDLE;
      op_q       <= MEM_NO;
      addr_q     <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      res_data_q <= res_data_d;
    end
  end

`ifdef MISALIGN_CHECK_EN
  // Misalign flag travels with the result it describes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end
  assign res_misalign = mis_q;
`else
  assign res_misalign = 1'b0;
`endif

  assign ld_ready   = (state_q == LD_IDLE);
  assign dmem_ren   = (state_q == LD_REQ);
  assign res_valid  = (state_q == LD_DONE);
  assign dmem_raddr = {addr_q[AW-1:3], 3'b000};
  assign res_data   = res_data_q;

endmodule
